// File: rtl/vic_pkg.sv
// ---------------------------------------------------------------------------
// vic_pkg
//  Shared constants and types for the VIC register file.
//  - 31 config registers at addresses 0..30, control register at address 31.
//  - Bit 0 of the control register is the engine enable.
// ---------------------------------------------------------------------------
package vic_pkg;

  localparam int VIC_DATA_W      = 4;
  localparam int VIC_ADDR_W      = 5;
  localparam int VIC_NUM_REGS    = 31;
  localparam int VIC_TOTAL_REGS  = VIC_NUM_REGS + 1;  // config regs + control
  localparam int VIC_BUF_W       = VIC_NUM_REGS * VIC_DATA_W;
  localparam int VIC_CTRL_EN_BIT = 0;

  localparam logic [VIC_ADDR_W-1:0] VIC_CTRL_ADDR = 5'd31;

  typedef logic [VIC_DATA_W-1:0] vic_data_t;
  typedef logic [VIC_ADDR_W-1:0] vic_addr_t;

endpackage : vic_pkg

// File: rtl/vic_reg_cell.sv
// ---------------------------------------------------------------------------
// vic_reg_cell
//  One register of the VIC register file: async active-high reset to zero,
//  synchronous load when load_i is high.
//  Ports:
//    clk     in   system clock
//    rst     in   asynchronous, active-high reset
//    load_i  in   load enable (address decode AND write enable)
//    d_i     in   data to store
//    q_o     out  stored value
// ---------------------------------------------------------------------------
module vic_reg_cell
  import vic_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  vic_data_t d_i,
  output vic_data_t q_o
);

  vic_data_t q_q;
  vic_data_t q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) q_d = d_i;
  end

  // NOTE: non-blocking update, so every cell and the read register sample the
  // same pre-edge values; this is what makes a same-cycle read see old data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q_o = q_q;

endmodule : vic_reg_cell

// File: rtl/vic_registers.sv
// ---------------------------------------------------------------------------
// vic_registers
//  Host-accessible register file for the VIC video block.
//  31 x 4-bit config registers (addr 0..30) are exposed in parallel on
//  o_buffer; the control register (addr 31) drives o_enable from bit 0.
//  Reads are registered (1-cycle latency) and hold when i_VIC_re is low.
//  Ports:
//    clk            in   system clock
//    rst            in   asynchronous, active-high reset
//    i_VIC_regaddr  in   register address 0..31
//    i_VIC_data     in   write data
//    o_VIC_data     out  registered read data
//    i_VIC_we       in   write enable
//    i_VIC_re       in   read enable
//    o_buffer       out  config regs packed, reg[i] at [4*i+3:4*i]
//    o_enable       out  engine enable (control reg bit 0)
// ---------------------------------------------------------------------------
module vic_registers
  import vic_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [VIC_ADDR_W-1:0] i_VIC_regaddr,
  input  logic [VIC_DATA_W-1:0] i_VIC_data,
  output logic [VIC_DATA_W-1:0] o_VIC_data,
  input  logic                 i_VIC_we,
  input  logic                 i_VIC_re,
  output logic [VIC_BUF_W-1:0]  o_buffer,
  output logic                 o_enable
);

  logic [VIC_TOTAL_REGS-1:0] load_dec;
  vic_data_t                 regs [VIC_TOTAL_REGS];
  vic_data_t                 rd_q;
  vic_data_t                 rd_d;

  // One-hot write decode; every address is valid, so no error path.
  // NOTE: default assigned first so no path leaves load_dec unassigned (no latch).
  always_comb begin
    load_dec = '0;
    if (i_VIC_we) load_dec[i_VIC_regaddr] = 1'b1;
  end

  // Registers 0..30 are config, register 31 is control.
  // NOTE: these are discrete flops with reset, not a RAM, because the whole
  // array must read zero on o_buffer immediately after reset.
  for (genvar i = 0; i < VIC_TOTAL_REGS; i++) begin : g_cell
    vic_reg_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .load_i (load_dec[i]),
      .d_i    (i_VIC_data),
      .q_o    (regs[i])
    );
  end

  // Read mux; the register holds its value when no read is requested.
  always_comb begin
    rd_d = rd_q;
    if (i_VIC_re) rd_d = regs[i_VIC_regaddr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign o_VIC_data = rd_q;

  for (genvar i = 0; i < VIC_NUM_REGS; i++) begin : g_buf
    assign o_buffer[VIC_DATA_W*i +: VIC_DATA_W] = regs[i];
  end

  assign o_enable = regs[VIC_CTRL_ADDR][VIC_CTRL_EN_BIT];

endmodule : vic_registers

// File: tb/tb_vic_registers.sv
// ---------------------------------------------------------------------------
// tb_vic_registers
//  Directed bench for vic_registers. A reference model of the 32 registers
//  supplies expected values; read expectations are queued when a read is
//  issued and compared when the registered read data appears.
// ---------------------------------------------------------------------------
module tb_vic_registers;
  import vic_pkg::*;

  logic                  clk;
  logic                  rst;
  logic [VIC_ADDR_W-1:0] addr;
  logic [VIC_DATA_W-1:0] wdata;
  logic [VIC_DATA_W-1:0] rdata;
  logic                  we;
  logic                  re;
  logic [VIC_BUF_W-1:0]  buffer;
  logic                  enable;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [3:0] model [32];
  logic [3:0] exp_q [$];
  logic [3:0] last_rd;

  vic_registers dut (
    .clk           (clk),
    .rst           (rst),
    .i_VIC_regaddr (addr),
    .i_VIC_data    (wdata),
    .o_VIC_data    (rdata),
    .i_VIC_we      (we),
    .i_VIC_re      (re),
    .o_buffer      (buffer),
    .o_enable      (enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [123:0] obs, input logic [123:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [123:0] model_buf();
    logic [123:0] b;
    b = '0;
    for (int i = 0; i < 31; i++) b[4*i +: 4] = model[i];
    return b;
  endfunction

  // One host cycle: drive on the falling edge, check 1 time unit after the
  // rising edge. A read's expectation is the pre-write model value.
  task automatic access(input logic w, input logic r, input logic [4:0] a,
                        input logic [3:0] d, input string tag);
    logic [3:0] e;
    @(negedge clk);
    we = w; re = r; addr = a; wdata = d;
    if (r) exp_q.push_back(model[a]);
    if (w) model[a] = d;
    @(posedge clk);
    #1;
    we = 1'b0; re = 1'b0;
    if (r) begin
      e = exp_q.pop_front();
      check({tag, " rd"}, 124'(rdata), 124'(e));
      last_rd = e;
    end else begin
      check({tag, " hold"}, 124'(rdata), 124'(last_rd));
    end
    check({tag, " buf"}, buffer, model_buf());
    check({tag, " en"}, 124'(enable), 124'(model[31][0]));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " buf"}, buffer, '0);
    check({tag, " rd"},  124'(rdata), '0);
    check({tag, " en"},  124'(enable), '0);
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    last_rd = '0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // 1: asynchronous reset, observed before any clock edge.
    #2 rst = 1'b1;
    #1 check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // 2: write/readback sweep over the config registers.
    for (int a = 0; a < 31; a++) begin
      logic [3:0] v;
      v = 4'($urandom_range(0, 15));
      access(1'b1, 1'b0, 5'(a), v, "sweep_wr");
      access(1'b0, 1'b1, 5'(a), 4'h0, "sweep_rd");
    end

    // 3: control register drives o_enable.
    access(1'b1, 1'b0, 5'd31, 4'hF, "ctrl_on");
    check("ctrl_on enable", 124'(enable), 124'(1'b1));
    access(1'b0, 1'b1, 5'd31, 4'h0, "ctrl_rd");
    check("ctrl_rd value", 124'(rdata), 124'(4'hF));
    access(1'b1, 1'b0, 5'd31, 4'h0, "ctrl_off");
    check("ctrl_off enable", 124'(enable), 124'(1'b0));
    access(1'b1, 1'b0, 5'd31, 4'h6, "ctrl_even");

    // 4: read during write at the same address returns the old value.
    access(1'b1, 1'b0, 5'd5, 4'h3, "rdw_setup");
    access(1'b1, 1'b1, 5'd5, 4'hA, "rdw_same");
    check("rdw_same old", 124'(rdata), 124'(4'h3));
    access(1'b0, 1'b1, 5'd5, 4'h0, "rdw_next");
    check("rdw_next new", 124'(rdata), 124'(4'hA));

    // 5: read data holds while writing elsewhere with re low.
    access(1'b1, 1'b0, 5'd7, 4'hC, "hold_setup");
    access(1'b0, 1'b1, 5'd7, 4'h0, "hold_rd");
    for (int i = 0; i < 10; i++)
      access(1'b1, 1'b0, 5'(10 + i), 4'(i + 1), "hold");

    // 6: load every register, then reset between clock edges.
    for (int a = 0; a < 32; a++)
      access(1'b1, 1'b0, 5'(a), 4'(a % 15 + 1), "load");
    access(1'b0, 1'b1, 5'd3, 4'h0, "load_rd");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midreset");
    for (int i = 0; i < 32; i++) model[i] = '0;
    last_rd = '0;
    @(negedge clk);
    rst = 1'b0;
    access(1'b0, 1'b1, 5'd0,  4'h0, "post_rst0");
    access(1'b0, 1'b1, 5'd30, 4'h0, "post_rst30");
    access(1'b0, 1'b1, 5'd31, 4'h0, "post_rst31");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_vic_registers
